// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard and sequencing controller for the 5-stage stalling RV32I
// pipeline (no forwarding). Detects RAW hazards against EX/MEM/WB producers,
// holds PC and IF/ID for the required number of cycles, bubbles ID/EX,
// flushes on taken branches resolved in EX and produces the next-PC value.
// Optional build macro: STALL_CTRL_PERF_EN adds the perf_stall_cycles and
// perf_flushes counters.
module stall_ctrl #(
  parameter int unsigned     PC_W         = 13,
  parameter logic [PC_W-1:0] RESET_PC     = {PC_W{1'b0}},
  parameter int unsigned     RF_WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] nxt_pc,
  output logic            pc_stall,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic            ex_valid,
  input  logic            ex_regwrite,
  input  logic [4:0]      ex_rd,
  input  logic            mem_valid,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic            wb_valid,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic            ex_branch_taken,
  input  logic [PC_W-1:0] ex_branch_target,
  output logic            ifid_stall,
  output logic            idex_bubble,
  output logic            ifid_flush,
  output logic            stall_active
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flushes
`endif
);

  // Stall cycles needed for a producer in each stage. With the write-first
  // register file the WB producer is visible on the same-cycle read.
  localparam logic [2:0]      EX_NEED  = 3'(32'd3 - RF_WB_BYPASS);
  localparam logic [2:0]      MEM_NEED = 3'(32'd2 - RF_WB_BYPASS);
  localparam logic [2:0]      WB_NEED  = 3'(32'd1 - RF_WB_BYPASS);
  localparam logic [PC_W-1:0] PC_INC   = PC_W'(32'd4);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t     state_r;
  logic [2:0] cnt_r;

  logic       ex_hit_s;
  logic       mem_hit_s;
  logic       wb_hit_s;
  logic [2:0] ex_need_s;
  logic [2:0] mem_need_s;
  logic [2:0] wb_need_s;
  logic [2:0] hz_need_s;

  // A producer matches when it will write a non-x0 register that ID reads.
  function automatic logic src_match(
    input logic       stg_valid,
    input logic       stg_we,
    input logic [4:0] stg_rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    logic hit;
    hit = stg_valid && stg_we && (stg_rd != 5'd0) &&
          ((rs1_used && (rs1 == stg_rd)) || (rs2_used && (rs2 == stg_rd)));
    return hit;
  endfunction

  function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  assign ex_hit_s  = id_valid && src_match(ex_valid, ex_regwrite, ex_rd,
                                           id_rs1, id_rs1_used, id_rs2, id_rs2_used);
  assign mem_hit_s = id_valid && src_match(mem_valid, mem_regwrite, mem_rd,
                                           id_rs1, id_rs1_used, id_rs2, id_rs2_used);
  assign wb_hit_s  = id_valid && src_match(wb_valid, wb_regwrite, wb_rd,
                                           id_rs1, id_rs1_used, id_rs2, id_rs2_used);

  assign ex_need_s  = ex_hit_s  ? EX_NEED  : 3'd0;
  assign mem_need_s = mem_hit_s ? MEM_NEED : 3'd0;
  assign wb_need_s  = wb_hit_s  ? WB_NEED  : 3'd0;
  assign hz_need_s  = max3(ex_need_s, max3(mem_need_s, wb_need_s));

  // Output decode: reset forcing, then branch redirect, then stall, then run.
  always_comb begin
    nxt_pc       = pc_i + PC_INC;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    stall_active = 1'b0;
    if (rst) begin
      nxt_pc = RESET_PC;
    end else if (ex_branch_taken) begin
      nxt_pc       = ex_branch_target;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      stall_active = (state_r == ST_STALL);
    end else if (state_r == ST_STALL) begin
      nxt_pc       = pc_i;
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_bubble  = 1'b1;
      stall_active = 1'b1;
    end else if (hz_need_s != 3'd0) begin
      nxt_pc      = pc_i;
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      nxt_pc = pc_i + PC_INC;
    end
  end

  // Sequencer: RUN evaluates hazards; STALL counts down the remaining cycles
  // without looking at hazard inputs. Reset and taken branches abort a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else if (ex_branch_taken) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hz_need_s > 3'd1) begin
            state_r <= ST_STALL;
            cnt_r   <= hz_need_s - 3'd1;
          end else begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
          end
        end
        ST_STALL: begin
          if (cnt_r <= 3'd1) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
          end else begin
            state_r <= ST_STALL;
            cnt_r   <= cnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  // Count cycles with PC held and cycles with IF/ID flushed; wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      perf_stall_r <= perf_stall_r + {31'd0, pc_stall};
      perf_flush_r <= perf_flush_r + {31'd0, ifid_flush};
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flushes      = perf_flush_r;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed and random checks of stall_ctrl, instantiated with
// and without the WB bypass, against a remaining-stall-cycles reference model.
module tb_stall_ctrl;

  localparam logic [12:0] RST_PC = 13'h040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [12:0] pc_i = 13'h100;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = 5'd0;
  logic [4:0]  id_rs2 = 5'd0;
  logic        id_rs1_used = 1'b0;
  logic        id_rs2_used = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_regwrite = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        mem_valid = 1'b0;
  logic        mem_regwrite = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic        wb_valid = 1'b0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic        ex_branch_taken = 1'b0;
  logic [12:0] ex_branch_target = 13'h000;

  logic [12:0] nxt_pc_a, nxt_pc_b;
  logic        pc_stall_a, pc_stall_b;
  logic        ifid_stall_a, ifid_stall_b;
  logic        idex_bubble_a, idex_bubble_b;
  logic        ifid_flush_a, ifid_flush_b;
  logic        stall_active_a, stall_active_b;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_a, perf_stall_b;
  logic [31:0] perf_flush_a, perf_flush_b;
  logic [31:0] m_ps_a = 32'd0, m_ps_b = 32'd0, m_pf_a = 32'd0, m_pf_b = 32'd0;
  bit          perf_known = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rem_a    = 0;
  int rem_b    = 0;

  stall_ctrl #(.PC_W(13), .RESET_PC(RST_PC), .RF_WB_BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .pc_i(pc_i), .nxt_pc(nxt_pc_a), .pc_stall(pc_stall_a),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ifid_stall(ifid_stall_a), .idex_bubble(idex_bubble_a),
    .ifid_flush(ifid_flush_a), .stall_active(stall_active_a)
`ifdef STALL_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_a), .perf_flushes(perf_flush_a)
`endif
  );

  stall_ctrl #(.PC_W(13), .RESET_PC(RST_PC), .RF_WB_BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .pc_i(pc_i), .nxt_pc(nxt_pc_b), .pc_stall(pc_stall_b),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ifid_stall(ifid_stall_b), .idex_bubble(idex_bubble_b),
    .ifid_flush(ifid_flush_b), .stall_active(stall_active_b)
`ifdef STALL_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_b), .perf_flushes(perf_flush_b)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk13(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Does a producer in some stage write a register the ID instruction reads?
  function automatic bit hits(input logic v, input logic w, input logic [4:0] rd);
    return v && w && (rd != 5'd0) &&
           ((id_rs1_used && id_rs1 == rd) || (id_rs2_used && id_rs2 == rd));
  endfunction

  // Stall cycles needed: a producer k stages ahead of WB needs (k+1 - bypass).
  function automatic int need(input int bypass);
    int n;
    n = 0;
    if (id_valid) begin
      if (hits(ex_valid, ex_regwrite, ex_rd) && (3 - bypass) > n) n = 3 - bypass;
      if (hits(mem_valid, mem_regwrite, mem_rd) && (2 - bypass) > n) n = 2 - bypass;
      if (hits(wb_valid, wb_regwrite, wb_rd) && (1 - bypass) > n) n = 1 - bypass;
    end
    return n;
  endfunction

  // Reference model: rem = committed stall cycles still owed after this one.
  task automatic model_cfg(input int bypass, inout int rem,
                           output logic [12:0] e_nxt, output logic e_pcs,
                           output logic e_ifs, output logic e_bub,
                           output logic e_fl, output logic e_sa);
    int n;
    n = need(bypass);
    e_nxt = pc_i + 13'd4;
    e_pcs = 1'b0; e_ifs = 1'b0; e_bub = 1'b0; e_fl = 1'b0; e_sa = 1'b0;
    if (rst) begin
      e_nxt = RST_PC;
      rem = 0;
    end else begin
      e_sa = (rem > 0);
      if (ex_branch_taken) begin
        e_nxt = ex_branch_target; e_fl = 1'b1; e_bub = 1'b1;
        rem = 0;
      end else if (rem > 0) begin
        e_nxt = pc_i; e_pcs = 1'b1; e_ifs = 1'b1; e_bub = 1'b1;
        rem = rem - 1;
      end else if (n > 0) begin
        e_nxt = pc_i; e_pcs = 1'b1; e_ifs = 1'b1; e_bub = 1'b1;
        rem = n - 1;
      end
    end
  endtask

  // Wait for the falling edge and compare both instances with the model.
  task automatic at_neg();
    logic [12:0] en;
    logic p, i, b, f, s;
    @(negedge clk);
    model_cfg(1, rem_a, en, p, i, b, f, s);
    chk13("A_nxt_pc", nxt_pc_a, en);
    chk1("A_pc_stall", pc_stall_a, p);
    chk1("A_ifid_stall", ifid_stall_a, i);
    chk1("A_idex_bubble", idex_bubble_a, b);
    chk1("A_ifid_flush", ifid_flush_a, f);
    chk1("A_stall_active", stall_active_a, s);
`ifdef STALL_CTRL_PERF_EN
    if (perf_known) begin
      chk32("A_perf_stall", perf_stall_a, m_ps_a);
      chk32("A_perf_flush", perf_flush_a, m_pf_a);
    end
    m_ps_a = rst ? 32'd0 : m_ps_a + {31'd0, p};
    m_pf_a = rst ? 32'd0 : m_pf_a + {31'd0, f};
`endif
    model_cfg(0, rem_b, en, p, i, b, f, s);
    chk13("B_nxt_pc", nxt_pc_b, en);
    chk1("B_pc_stall", pc_stall_b, p);
    chk1("B_ifid_stall", ifid_stall_b, i);
    chk1("B_idex_bubble", idex_bubble_b, b);
    chk1("B_ifid_flush", ifid_flush_b, f);
    chk1("B_stall_active", stall_active_b, s);
`ifdef STALL_CTRL_PERF_EN
    if (perf_known) begin
      chk32("B_perf_stall", perf_stall_b, m_ps_b);
      chk32("B_perf_flush", perf_flush_b, m_pf_b);
    end
    m_ps_b = rst ? 32'd0 : m_ps_b + {31'd0, p};
    m_pf_b = rst ? 32'd0 : m_pf_b + {31'd0, f};
    if (rst) perf_known = 1'b1;
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; mem_valid = 1'b0; wb_valid = 1'b0;
    ex_regwrite = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic ex_hazard(input logic [4:0] r);
    quiet();
    id_valid = 1'b1; id_rs1 = r; id_rs1_used = 1'b1;
    ex_valid = 1'b1; ex_regwrite = 1'b1; ex_rd = r;
  endtask

  initial begin
    // Reset for two cycles.
    rst = 1'b1; pc_i = 13'h100;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk13("rst_nxt_pc", nxt_pc_a, 13'h040);
      chk1("rst_pc_stall", pc_stall_a, 1'b0);
      chk1("rst_flush", ifid_flush_b, 1'b0);
      adv();
    end
    // Free running after release.
    quiet();
    for (int k = 0; k < 3; k++) begin
      pc_i = 13'h200 + 13'(k * 4);
      at_neg();
      chk13("run_nxt_pc", nxt_pc_a, 13'h204 + 13'(k * 4));
      adv();
    end

    // EX RAW with the producer advancing one stage per cycle.
    pc_i = 13'h100; ex_hazard(5'd5);
    at_neg(); chk1("exraw_c1_A", pc_stall_a, 1'b1); chk13("exraw_c1_pc", nxt_pc_a, 13'h100);
    chk1("exraw_c1_B", pc_stall_b, 1'b1); adv();
    ex_valid = 1'b0; mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd5;
    at_neg(); chk1("exraw_c2_A", pc_stall_a, 1'b1); chk13("exraw_c2_pc", nxt_pc_a, 13'h100);
    chk1("exraw_c2_bub", idex_bubble_a, 1'b1); adv();
    mem_valid = 1'b0; wb_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd5;
    at_neg(); chk1("exraw_c3_A", pc_stall_a, 1'b0); chk13("exraw_c3_pc", nxt_pc_a, 13'h104);
    chk1("exraw_c3_B", pc_stall_b, 1'b1); adv();
    wb_valid = 1'b0;
    at_neg(); chk1("exraw_c4_B", pc_stall_b, 1'b0); adv();

    // MEM match on rs2.
    quiet(); id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd7;
    at_neg(); chk1("mem_c1_A", pc_stall_a, 1'b1); chk1("mem_c1_B", pc_stall_b, 1'b1); adv();
    mem_valid = 1'b0; wb_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd7;
    at_neg(); chk1("mem_c2_A", pc_stall_a, 1'b0); chk1("mem_c2_B", pc_stall_b, 1'b1); adv();
    quiet();
    at_neg(); chk1("mem_c3_B", pc_stall_b, 1'b0); adv();

    // x0 never creates a hazard.
    ex_hazard(5'd0);
    at_neg(); chk1("x0_A", pc_stall_a, 1'b0); chk1("x0_B", pc_stall_b, 1'b0); adv();

    // WB match: only the non-bypassed instance stalls.
    quiet(); id_valid = 1'b1; id_rs1 = 5'd9; id_rs1_used = 1'b1;
    wb_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd9;
    at_neg(); chk1("wb_A", pc_stall_a, 1'b0); chk1("wb_B", pc_stall_b, 1'b1); adv();
    quiet();
    at_neg(); chk1("wb_rel_B", pc_stall_b, 1'b0); adv();

    // Taken branch in the second stall cycle.
    pc_i = 13'h100; ex_hazard(5'd5);
    at_neg(); chk1("br_c1_stall", pc_stall_a, 1'b1); adv();
    ex_branch_taken = 1'b1; ex_branch_target = 13'h0A0;
    at_neg();
    chk1("br_flush", ifid_flush_a, 1'b1); chk1("br_bubble", idex_bubble_a, 1'b1);
    chk1("br_pc_stall", pc_stall_a, 1'b0); chk1("br_ifid_stall", ifid_stall_a, 1'b0);
    chk13("br_nxt_pc", nxt_pc_a, 13'h0A0); chk13("br_nxt_pc_B", nxt_pc_b, 13'h0A0);
    adv();
    quiet();
    at_neg(); chk1("br_after_A", stall_active_a, 1'b0); chk1("br_after_B", stall_active_b, 1'b0); adv();

    // PC wrap.
    pc_i = 13'h1FFC;
    at_neg(); chk13("wrap_A", nxt_pc_a, 13'h0000); chk13("wrap_B", nxt_pc_b, 13'h0000); adv();

    // Reset while the bypassed instance sits in its last stall cycle.
    pc_i = 13'h100; ex_hazard(5'd3);
    at_neg(); chk1("rstm_c1", pc_stall_a, 1'b1); adv();
    rst = 1'b1;
    at_neg(); chk1("rstm_c2_stall", pc_stall_a, 1'b0); chk1("rstm_c2_sa", stall_active_a, 1'b0);
    chk13("rstm_c2_pc", nxt_pc_a, 13'h040); adv();
    quiet();
    at_neg(); chk1("rstm_c3_stall", pc_stall_a, 1'b0); chk1("rstm_c3_sa", stall_active_b, 1'b0);
    chk13("rstm_c3_pc", nxt_pc_a, 13'h104);
`ifdef STALL_CTRL_PERF_EN
    chk32("rstm_perf_clr", perf_stall_a, 32'd0);
`endif
    adv();

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      rst              = ($urandom_range(0, 39) == 0);
      pc_i             = 13'($urandom) & 13'h1FFC;
      id_valid         = ($urandom_range(0, 3) != 0);
      id_rs1           = 5'($urandom_range(0, 3));
      id_rs2           = 5'($urandom_range(0, 3));
      id_rs1_used      = 1'($urandom_range(0, 1));
      id_rs2_used      = 1'($urandom_range(0, 1));
      ex_valid         = 1'($urandom_range(0, 1));
      ex_regwrite      = 1'($urandom_range(0, 1));
      ex_rd            = 5'($urandom_range(0, 3));
      mem_valid        = 1'($urandom_range(0, 1));
      mem_regwrite     = 1'($urandom_range(0, 1));
      mem_rd           = 5'($urandom_range(0, 3));
      wb_valid         = 1'($urandom_range(0, 1));
      wb_regwrite      = 1'($urandom_range(0, 1));
      wb_rd            = 5'($urandom_range(0, 3));
      ex_branch_taken  = ($urandom_range(0, 9) == 0);
      ex_branch_target = 13'($urandom) & 13'h1FFC;
      at_neg();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
